code_sequencer: RTL and testbench

CODE_SEQUENCER -- requirements
Module: code_sequencer

---
 rtl/code_sequencer.sv | 149 ++++++++++++++
 tb/tb_code_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/code_sequencer.sv
// Button-driven code sequencer: stores up to three switch digits, then plays them back on x.
// Optional feature: define SEQ_AUTOCLEAR_EN to clear stored digits after TIMEOUT idle cycles.
module code_sequencer #(
    parameter int          DEB_CYCLES = 4,
    parameter logic [2:0]  IDLE_CODE  = 3'b000,
    parameter int          TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw,
    input  logic       key,
    input  logic       go,
    output logic [2:0] x,
    output logic       busy,
    output logic [1:0] count,
    output logic       err
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic {COLLECT, PLAY} state_t;

    // Handshake: key/go are level inputs; each produces a one-cycle event on the
    // 0->1 edge of its debounced level. There is no valid/ready backpressure.
    logic [2:0]         sw_s1_q, sw_s2_q;
    logic [1:0]         btn_s1_q, btn_s2_q;      // [0]=key, [1]=go
    logic [1:0]         db_q, db_d, db_dly_q;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic               key_evt, go_evt;

    state_t             state_q, state_d;
    logic [2:0]         x_q, x_d;
    logic [1:0]         count_q, count_d;
    logic               err_q, err_d;
    logic [1:0]         idx_q, idx_d;
    logic [2:0][2:0]    dig_q, dig_d;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (btn_s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) db_d[i] = btn_s2_q[i];
                else                                  cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign key_evt = db_q[0] & ~db_dly_q[0];
    assign go_evt  = db_q[1] & ~db_dly_q[1];

`ifdef SEQ_AUTOCLEAR_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_q, idle_d;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = IDLE_CODE;
        count_d = count_q;
        err_d   = err_q;
        idx_d   = idx_q;
        dig_d   = dig_q;
`ifdef SEQ_AUTOCLEAR_EN
        idle_d  = '0;
`endif
        case (state_q)
            COLLECT: begin
                // A play event takes priority and swallows a coincident key event.
                if (go_evt && count_q != 2'd0) begin
                    state_d = PLAY;
                    x_d     = dig_q[0];
                    idx_d   = 2'd1;
                end else if (key_evt) begin
                    if (count_q != 2'd3) begin
                        dig_d[count_q] = sw_s2_q;
                        count_d        = count_q + 2'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`ifdef SEQ_AUTOCLEAR_EN
                else if (count_q != 2'd0) begin
                    if (idle_q == TW'(TIMEOUT - 1)) begin
                        count_d = 2'd0;
                        err_d   = 1'b0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
`endif
            end
            PLAY: begin
                if (idx_q == count_q) begin
                    state_d = COLLECT;
                    count_d = 2'd0;
                    err_d   = 1'b0;
                    idx_d   = 2'd0;
                end else begin
                    x_d   = dig_q[idx_q];
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            cnt_q    <= '0;
            state_q  <= COLLECT;
            x_q      <= IDLE_CODE;
            count_q  <= '0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            dig_q    <= '0;
`ifdef SEQ_AUTOCLEAR_EN
            idle_q   <= '0;
`endif
        end else begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= {go, key};
            btn_s2_q <= btn_s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            x_q      <= x_d;
            count_q  <= count_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            dig_q    <= dig_d;
`ifdef SEQ_AUTOCLEAR_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign x     = x_q;
    assign busy  = (state_q == PLAY);
    assign count = count_q;
    assign err   = err_q;
endmodule

// File: tb/tb_code_sequencer.sv
// Directed bench for code_sequencer: table of key presses plus hand-written play/reset sequences.
module tb_code_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sw;
    logic       key;
    logic       go;
    logic [2:0] x;
    logic       busy;
    logic [1:0] count;
    logic       err;

    always #5 clk = ~clk;

    code_sequencer #(.DEB_CYCLES(4), .IDLE_CODE(3'b000), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .sw(sw), .key(key), .go(go),
        .x(x), .busy(busy), .count(count), .err(err)
    );

    typedef struct {
        logic [2:0] d;
        logic [1:0] exp_count;
        logic       exp_err;
    } key_vec_t;

    key_vec_t   tv[7];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] cap_x[48];
    logic       cap_b[48];
    int         max_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input logic [2:0] d);
        sw = d;
        cycles(2);
        key = 1'b1;
        cycles(12);
        key = 1'b0;
        cycles(12);
    endtask

    task automatic play_capture();
        max_cnt = 0;
        go = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            cap_x[i] = x;
            cap_b[i] = busy;
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        go = 1'b0;
        cycles(12);
    endtask

    task automatic check_play(input string name, input logic [2:0] e[3], input int n);
        int f     = -1;
        int nb    = 0;
        int stray = 0;
        for (int i = 0; i < 48; i++) begin
            if (cap_b[i]) begin
                nb++;
                if (f < 0) f = i;
            end else if (cap_x[i] !== 3'b000) begin
                stray++;
            end
        end
        check({name, " busy cycles"}, nb, n);
        check({name, " idle x"}, stray, 0);
        if (n > 0) begin
            check({name, " started"}, {31'd0, f >= 0}, 1);
            if (f >= 0) begin
                for (int k = 0; k < n; k++) begin
                    if (f + k < 48) begin
                        check({name, " digit"}, {29'd0, cap_x[f+k]}, {29'd0, e[k]});
                        check({name, " contiguous"}, {31'd0, cap_b[f+k]}, 1);
                    end
                end
            end
        end
        check({name, " count after"}, count, 0);
        check({name, " err after"}, err, 0);
    endtask

    initial begin
        tv[0] = '{3'b011, 2'd1, 1'b0};
        tv[1] = '{3'b111, 2'd2, 1'b0};
        tv[2] = '{3'b101, 2'd3, 1'b0};
        tv[3] = '{3'b001, 2'd1, 1'b0};
        tv[4] = '{3'b010, 2'd2, 1'b0};
        tv[5] = '{3'b011, 2'd3, 1'b0};
        tv[6] = '{3'b100, 2'd3, 1'b1};

        reset = 1'b0; key = 1'b0; go = 1'b0; sw = 3'b000;
        cycles(3);
        check("reset x", x, 0);
        check("reset busy", busy, 0);
        check("reset count", count, 0);
        check("reset err", err, 0);
        reset = 1'b1;
        cycles(3);

        // Three clean presses then play
        for (int i = 0; i < 3; i++) begin
            press_key(tv[i].d);
            check("store count", count, tv[i].exp_count);
            check("store err", err, tv[i].exp_err);
        end
        play_capture();
        check_play("play3", '{3'b011, 3'b111, 3'b101}, 3);

        // Overflow: fourth digit discarded, err set until play
        for (int i = 3; i < 7; i++) begin
            press_key(tv[i].d);
            check("ovf count", count, tv[i].exp_count);
            check("ovf err", err, tv[i].exp_err);
        end
        play_capture();
        check_play("play_ovf", '{3'b001, 3'b010, 3'b011}, 3);

        // Bouncy key: 2-cycle glitches never reach the debounce threshold
        sw = 3'b110;
        cycles(2);
        for (int i = 0; i < 5; i++) begin
            key = 1'b1; cycles(2);
            key = 1'b0; cycles(2);
        end
        key = 1'b1;
        cycles(12);
        check("bounce count held", count, 1);
        key = 1'b0;
        cycles(12);
        check("bounce count", count, 1);
        play_capture();
        check_play("play_bounce", '{3'b110, 3'b000, 3'b000}, 1);

        // Play with nothing stored is ignored
        play_capture();
        check_play("play_empty", '{3'b000, 3'b000, 3'b000}, 0);

        // Simultaneous key and go events: play wins
        press_key(3'b111);
        press_key(3'b001);
        sw = 3'b010;
        cycles(2);
        key = 1'b1;
        play_capture();
        key = 1'b0;
        cycles(12);
        check("simul max count", max_cnt, 2);
        check_play("play_simul", '{3'b111, 3'b001, 3'b000}, 2);

        // Reset during the second played digit
        press_key(3'b010);
        press_key(3'b101);
        go = 1'b1;
        begin
            int waited = 0;
            while (!busy && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            check("rst wait busy", busy, 1);
        end
        @(negedge clk);
        check("rst second digit", x, 3'b101);
        #1 reset = 1'b0;
        #1;
        check("rst x", x, 0);
        check("rst busy", busy, 0);
        check("rst count", count, 0);
        @(negedge clk);
        reset = 1'b1;
        begin
            int extra = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (busy || x !== 3'b000) extra++;
            end
            check("rst no more digits", extra, 0);
        end
        go = 1'b0;
        cycles(12);
        check("rst count after", count, 0);

        // Button held through reset release gives exactly one event
        reset = 1'b0;
        key = 1'b1;
        sw = 3'b100;
        cycles(3);
        reset = 1'b1;
        cycles(20);
        check("held key count", count, 1);
        cycles(20);
        check("held key single", count, 1);
        key = 1'b0;
        cycles(12);
        play_capture();
        check_play("play_held", '{3'b100, 3'b000, 3'b000}, 1);

`ifdef SEQ_AUTOCLEAR_EN
        press_key(3'b011);
        cycles(50);
        check("autoclear count", count, 0);
        press_key(3'b011);
        play_capture();
        check_play("play_before_timeout", '{3'b011, 3'b000, 3'b000}, 1);
`else
        press_key(3'b011);
        cycles(1200);
        check("persist count", count, 1);
        play_capture();
        check_play("play_persist", '{3'b011, 3'b000, 3'b000}, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
